vid_rd_sched: RTL and testbench

- Frame-buffer read scheduler between the 1024x768 display timing generator and the DDR3 read port arbiter.
- Sequences burst reads of one frame from DDR3 into the display pixel FIFO, paced by FIFO fill level.
- Restarts at every vertical sync and clears the FIFO.
- Flags underflow when the display consumes pixels from an empty FIFO.

---
 rtl/vid_rd_sched_if.sv | 40 ++++
 rtl/vid_rd_sched.sv | 180 ++++++++++++++++++
 tb/tb_vid_rd_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vid_rd_sched_if.sv
// Display-side and DDR3 read-port signal bundle for vid_rd_sched.
// The buffer-index pair exists only when VID_RD_SCHED_PINGPONG_EN is defined.
interface vid_rd_sched_if #(
    parameter int ADDR_W = 28
);
    logic              vs_in;
    logic              de_in;
    logic [10:0]       fifo_level;
    logic              rd_req;
    logic              rd_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_done;
    logic              fifo_clr;
    logic              frame_start;
    logic              underflow;
    logic              busy;
`ifdef VID_RD_SCHED_PINGPONG_EN
    logic              wr_buf_idx;
    logic              rd_buf_idx;

    modport master (
        input  vs_in, de_in, fifo_level, rd_ack, rd_done, wr_buf_idx,
        output rd_req, rd_addr, rd_len, fifo_clr, frame_start, underflow, busy, rd_buf_idx
    );
    modport slave (
        output vs_in, de_in, fifo_level, rd_ack, rd_done, wr_buf_idx,
        input  rd_req, rd_addr, rd_len, fifo_clr, frame_start, underflow, busy, rd_buf_idx
    );
`else
    modport master (
        input  vs_in, de_in, fifo_level, rd_ack, rd_done,
        output rd_req, rd_addr, rd_len, fifo_clr, frame_start, underflow, busy
    );
    modport slave (
        output vs_in, de_in, fifo_level, rd_ack, rd_done,
        input  rd_req, rd_addr, rd_len, fifo_clr, frame_start, underflow, busy
    );
`endif
endinterface

// File: rtl/vid_rd_sched.sv
// Frame-buffer read scheduler: paces DDR3 burst reads into the display pixel FIFO.
// Optional double buffering is enabled by defining VID_RD_SCHED_PINGPONG_EN.
module vid_rd_sched #(
    parameter int                H_ACTIVE   = 1024,
    parameter int                V_ACTIVE   = 768,
    parameter int                BURST_LEN  = 64,
    parameter int                PIX_BYTES  = 2,
    parameter int                FIFO_DEPTH = 1024,
    parameter int                ADDR_W     = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 28'h0,
    parameter int                FLUSH_CYC  = 4,
    parameter logic              VS_POL     = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    vid_rd_sched_if.master bus
);
    localparam int                 TOTAL_BURSTS = H_ACTIVE * V_ACTIVE / BURST_LEN;
    localparam int                 CNT_W        = $clog2(TOTAL_BURSTS + 1);
    localparam int                 FCNT_W       = $clog2(FLUSH_CYC + 1);
    localparam logic [ADDR_W-1:0]  STRIDE       = ADDR_W'(BURST_LEN * PIX_BYTES);
    localparam logic [10:0]        REQ_THRESH   = 11'(FIFO_DEPTH - BURST_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(TOTAL_BURSTS);
    localparam logic [FCNT_W-1:0]  FLUSH_LAST   = FCNT_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_CHECK, S_REQ, S_WAIT_DONE, S_DONE
    } state_t;

    state_t              state_r, state_s;
    logic                vs_r;
    logic                vs_start_s;
    logic                pend_r, pend_s;
    logic [FCNT_W-1:0]   fcnt_r;
    logic [CNT_W-1:0]    bcnt_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [ADDR_W-1:0]   base_s;
    logic                flush_first_s;
    logic                advance_s;
    logic                busy_s;
    logic                rd_req_r, fifo_clr_r, frame_start_r, underflow_r, busy_r;

    assign vs_start_s    = (bus.vs_in == VS_POL) && (vs_r != VS_POL);
    assign flush_first_s = (state_r == S_FLUSH) && (fcnt_r == '0);
    assign advance_s     = (state_r == S_WAIT_DONE) && (state_s == S_CHECK);

`ifdef VID_RD_SCHED_PINGPONG_EN
    localparam logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(H_ACTIVE * V_ACTIVE * PIX_BYTES);
    logic buf_idx_r;

    // The reader always takes the buffer the writer is not filling.
    assign base_s         = bus.wr_buf_idx ? BASE_ADDR : (BASE_ADDR + FRAME_BYTES);
    assign bus.rd_buf_idx = buf_idx_r;

    // Buffer index latched once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_idx_r <= 1'b0;
        end else if (flush_first_s) begin
            buf_idx_r <= ~bus.wr_buf_idx;
        end else begin
            buf_idx_r <= buf_idx_r;
        end
    end
`else
    assign base_s = BASE_ADDR;
`endif

    // Next-state logic; a vsync that lands while a burst is in flight is deferred via pend.
    always_comb begin
        state_s = state_r;
        pend_s  = pend_r;
        case (state_r)
            S_IDLE: begin
                if (vs_start_s) state_s = S_FLUSH;
                else            state_s = S_IDLE;
            end
            S_FLUSH: begin
                pend_s = 1'b0;
                if (fcnt_r == FLUSH_LAST) state_s = S_CHECK;
                else                      state_s = S_FLUSH;
            end
            S_CHECK: begin
                if (vs_start_s)                         state_s = S_FLUSH;
                else if (bcnt_r == CNT_LAST)            state_s = S_DONE;
                else if (bus.fifo_level <= REQ_THRESH)  state_s = S_REQ;
                else                                    state_s = S_CHECK;
            end
            S_REQ: begin
                if (bus.rd_ack) begin
                    state_s = S_WAIT_DONE;
                    pend_s  = vs_start_s;
                end else if (vs_start_s) begin
                    state_s = S_FLUSH;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT_DONE: begin
                if (bus.rd_done) begin
                    pend_s = 1'b0;
                    if (pend_r || vs_start_s) state_s = S_FLUSH;
                    else                      state_s = S_CHECK;
                end else if (vs_start_s) begin
                    pend_s = 1'b1;
                end else begin
                    pend_s = pend_r;
                end
            end
            S_DONE: begin
                if (vs_start_s) state_s = S_FLUSH;
                else            state_s = S_DONE;
            end
            default: begin
                state_s = S_IDLE;
                pend_s  = 1'b0;
            end
        endcase
        busy_s = (state_s == S_FLUSH) || (state_s == S_CHECK) ||
                 (state_s == S_REQ)   || (state_s == S_WAIT_DONE);
    end

    // State, sync history, flush timer, burst address/count and sticky underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            pend_r      <= 1'b0;
            vs_r        <= ~VS_POL;
            fcnt_r      <= '0;
            bcnt_r      <= '0;
            rd_addr_r   <= BASE_ADDR;
            underflow_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
            vs_r    <= bus.vs_in;
            fcnt_r  <= (state_r == S_FLUSH) ? fcnt_r + 1'b1 : '0;
            if (flush_first_s) begin
                rd_addr_r <= base_s;
                bcnt_r    <= '0;
            end else if (advance_s) begin
                rd_addr_r <= rd_addr_r + STRIDE;
                bcnt_r    <= bcnt_r + 1'b1;
            end else begin
                rd_addr_r <= rd_addr_r;
                bcnt_r    <= bcnt_r;
            end
            if (frame_start_r) begin
                underflow_r <= 1'b0;
            end else if (bus.de_in && (bus.fifo_level == 11'd0) && (state_r != S_FLUSH)) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    // Control outputs are registered from the state being entered so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_req_r      <= 1'b0;
            fifo_clr_r    <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            rd_req_r      <= (state_s == S_REQ);
            fifo_clr_r    <= (state_s == S_FLUSH);
            frame_start_r <= (state_s == S_FLUSH) && (state_r != S_FLUSH);
            busy_r        <= busy_s;
        end
    end

    assign bus.rd_req      = rd_req_r;
    assign bus.rd_addr     = rd_addr_r;
    assign bus.rd_len      = 8'(BURST_LEN);
    assign bus.fifo_clr    = fifo_clr_r;
    assign bus.frame_start = frame_start_r;
    assign bus.underflow   = underflow_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_vid_rd_sched.sv
// Scoreboard bench for vid_rd_sched: directed frame scenarios, a DDR3 responder and a monitor.
// Define VID_RD_SCHED_PINGPONG_EN on both RTL and bench to exercise the second buffer.
module tb_vid_rd_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vid_rd_sched_if #(.ADDR_W(28)) bus ();
    vid_rd_sched dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef VID_RD_SCHED_PINGPONG_EN
    localparam logic [27:0] FB = 28'h180000;
`else
    localparam logic [27:0] FB = 28'h0;
`endif

    int          checks   = 0;
    int          errors   = 0;
    logic [27:0] exp_q[$];
    int          acc_cnt  = 0;
    logic [27:0] last_addr = 28'h0;
    int          resp_dly = 2;
    bit          resp_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_cnt < n && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        chk("acc_timeout", 32'(acc_cnt >= n), 32'd1);
    endtask

    task automatic wait_clr(input int budget);
        int k = 0;
        while (!bus.fifo_clr && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("clr_timeout", 32'(bus.fifo_clr), 32'd1);
    endtask

    // DDR3 arbiter model: ack after resp_dly cycles of rd_req, rd_done resp_dly cycles later.
    initial begin
        int  ack_cnt  = 0;
        int  done_cnt = 0;
        bit  in_flight = 1'b0;
        bus.rd_ack  = 1'b0;
        bus.rd_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_ack  = 1'b0;
            bus.rd_done = 1'b0;
            if (in_flight) begin
                if (!resp_hold) begin
                    if (done_cnt >= resp_dly) begin
                        bus.rd_done = 1'b1;
                        in_flight   = 1'b0;
                    end else begin
                        done_cnt++;
                    end
                end
            end else if (bus.rd_req) begin
                if (ack_cnt >= resp_dly) begin
                    bus.rd_ack = 1'b1;
                    ack_cnt    = 0;
                    done_cnt   = 0;
                    in_flight  = 1'b1;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Monitor: scoreboard on accepted requests, fifo_clr run length, frame_start placement.
    initial begin
        bit          clr_prev = 1'b0;
        int          clr_run  = 0;
        logic [27:0] e;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (bus.fifo_clr && !clr_prev) chk("frame_start_first", 32'(bus.frame_start), 32'd1);
                else                           chk("frame_start_extra", 32'(bus.frame_start), 32'd0);
                if (bus.fifo_clr) begin
                    clr_run++;
                end else if (clr_prev) begin
                    chk("fifo_clr_len", 32'(clr_run), 32'd4);
                    clr_run = 0;
                end
                clr_prev = bus.fifo_clr;
                if (bus.rd_req && bus.rd_ack) begin
                    acc_cnt++;
                    last_addr = bus.rd_addr;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req", 32'(bus.rd_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_addr", 32'(bus.rd_addr), 32'(e));
                    end
                    chk("rd_len", 32'(bus.rd_len), 32'd64);
                end
            end
        end
    end

    initial begin
        int k;
        int base;
        rst            = 1'b1;
        bus.vs_in      = 1'b1;
        bus.de_in      = 1'b0;
        bus.fifo_level = 11'd0;
`ifdef VID_RD_SCHED_PINGPONG_EN
        bus.wr_buf_idx = 1'b0;
`endif
        repeat (10) @(negedge clk);
        chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_underflow", 32'(bus.underflow), 32'd0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst_fifo_clr", 32'(bus.fifo_clr), 32'd0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        chk("rst_rd_len", 32'(bus.rd_len), 32'd64);
`ifdef VID_RD_SCHED_PINGPONG_EN
        chk("rst_rd_buf_idx", 32'(bus.rd_buf_idx), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // First three bursts of a frame with an empty FIFO.
        exp_q.push_back(FB);
        exp_q.push_back(FB + 28'h80);
        exp_q.push_back(FB + 28'h100);
        bus.vs_in = 1'b0;
        @(negedge clk);
        chk("clr_latency", 32'(bus.fifo_clr), 32'd1);
        chk("busy_flush", 32'(bus.busy), 32'd1);
        repeat (4) @(negedge clk);
        chk("req_not_early", 32'(bus.rd_req), 32'd0);
        @(negedge clk);
        chk("req_latency", 32'(bus.rd_req), 32'd1);
        wait_acc(3, 200);
        bus.fifo_level = 11'd961;
        bus.vs_in      = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold_961_req", 32'(bus.rd_req), 32'd0);
        chk("hold_961_busy", 32'(bus.busy), 32'd1);
        chk("addr_after_3", 32'(bus.rd_addr), 32'(FB + 28'h180));
        chk("no_underflow", 32'(bus.underflow), 32'd0);

        // Threshold boundary: 960 requests on the following cycle.
        resp_hold = 1'b1;
        exp_q.push_back(FB + 28'h180);
        bus.fifo_level = 11'd960;
        @(negedge clk);
        chk("req_at_960", 32'(bus.rd_req), 32'd1);
        wait_acc(4, 50);

        // Vsync while a burst is outstanding: restart deferred until rd_done.
        bus.vs_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("pend_no_req", 32'(bus.rd_req), 32'd0);
            chk("pend_no_clr", 32'(bus.fifo_clr), 32'd0);
        end
        exp_q.push_back(FB);
        resp_hold = 1'b0;
        wait_clr(20);
        wait_acc(5, 100);
        bus.fifo_level = 11'd961;
        repeat (10) @(negedge clk);
        chk("addr_after_restart", 32'(bus.rd_addr), 32'(FB + 28'h80));
        bus.vs_in = 1'b1;

        // Full frame, FIFO always drained; de_in during flush must not flag underflow.
        resp_dly = 0;
        for (int i = 0; i < 12288; i++) exp_q.push_back(FB + 28'(i * 128));
        base = acc_cnt;
        repeat (2) @(negedge clk);
        bus.fifo_level = 11'd0;
        bus.vs_in      = 1'b0;
        @(negedge clk);
        chk("frame_clr", 32'(bus.fifo_clr), 32'd1);
        bus.de_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.de_in = 1'b0;
        chk("uf_masked_in_flush", 32'(bus.underflow), 32'd0);
        k = 0;
        while (bus.busy && k < 45000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_timeout", 32'(bus.busy), 32'd0);
        chk("frame_bursts", 32'(acc_cnt - base), 32'd12288);
        chk("last_addr", 32'(last_addr), 32'(FB + 28'h17FF80));
        repeat (5) @(negedge clk);
        chk("done_no_req", 32'(bus.rd_req), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("frame_queue_empty", 32'(exp_q.size()), 32'd0);

        // Underflow is sticky until the next frame_start.
        bus.de_in = 1'b1;
        @(negedge clk);
        bus.de_in = 1'b0;
        chk("uf_set", 32'(bus.underflow), 32'd1);
        repeat (5) @(negedge clk);
        chk("uf_sticky", 32'(bus.underflow), 32'd1);
        bus.fifo_level = 11'd961;
        bus.vs_in      = 1'b1;
        repeat (2) @(negedge clk);
        bus.vs_in = 1'b0;
        wait_clr(10);
        @(negedge clk);
        chk("uf_cleared", 32'(bus.underflow), 32'd0);
`ifdef VID_RD_SCHED_PINGPONG_EN
        chk("rd_buf_idx", 32'(bus.rd_buf_idx), 32'd1);
`endif
        repeat (10) @(negedge clk);
        chk("final_no_req", 32'(bus.rd_req), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
